// File: rtl/ctrl_pkg.sv
// Shared definitions for the sequencing instruction controller: opcodes,
// FSM states, state_signal encodings and instruction field offsets.
package ctrl_pkg;

    localparam logic [4:0] OP_NOP       = 5'b00000;
    localparam logic [4:0] OP_COMPUTE_W = 5'b00001;
    localparam logic [4:0] OP_COMPUTE_I = 5'b00010;
    localparam logic [4:0] OP_DRAIN     = 5'b00011;
    localparam logic [4:0] OP_LOAD_INP  = 5'b00100;
    localparam logic [4:0] OP_LOAD_WT   = 5'b00101;
    localparam logic [4:0] OP_SEND      = 5'b00110;
    localparam logic [4:0] OP_ACC_RST   = 5'b00111;

    localparam logic [1:0] SS_IDLE = 2'b00;
    localparam logic [1:0] SS_MOVE = 2'b01;
    localparam logic [1:0] SS_COMP = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_SEND    = 2'd3
    } state_e;

    // Fields are packed LSB-first: opcode, addr, data, count.
    localparam int OPC_LSB = 0;

    function automatic int addr_lsb(input int opc_w);
        return opc_w;
    endfunction

    function automatic int data_lsb(input int opc_w, input int addr_w);
        return opc_w + addr_w;
    endfunction

    function automatic int cnt_lsb(input int opc_w, input int addr_w, input int data_w);
        return opc_w + addr_w + data_w;
    endfunction

endpackage

// File: rtl/controller_seq_if.sv
// Instruction handshake plus buffer/accumulator control bus.
// Handshake: an instruction is consumed on a rising edge where instr_valid
// and instr_ready are both 1; while instr_ready is 0 the source holds
// instr_valid and instruction stable.
interface controller_seq_if #(
    parameter int INSTR_W    = 64,
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 32,
    parameter int OUT_ADDR_W = 4
);
    logic                  instr_valid;
    logic [INSTR_W-1:0]    instruction;
    logic                  instr_ready;
    logic                  inp_buf_we;
    logic [ADDR_W-1:0]     inp_buf_addr;
    logic [DATA_W-1:0]     inp_buf_data;
    logic                  wt_buf_we;
    logic [ADDR_W-1:0]     wt_buf_addr;
    logic [DATA_W-1:0]     wt_buf_data;
    logic                  acc_result_to_op_buf;
    logic [OUT_ADDR_W-1:0] acc_to_op_buf_addr;
    logic                  op_buffer_instr_for_sending_data;
    logic [OUT_ADDR_W-1:0] out_buf_addr;
    logic                  instr_for_accum_to_reset;
    logic [1:0]            state_signal;
    logic                  i_mode;
    logic                  illegal_op;

    modport master (
        output instr_valid, instruction,
        input  instr_ready, inp_buf_we, inp_buf_addr, inp_buf_data,
               wt_buf_we, wt_buf_addr, wt_buf_data,
               acc_result_to_op_buf, acc_to_op_buf_addr,
               op_buffer_instr_for_sending_data, out_buf_addr,
               instr_for_accum_to_reset, state_signal, i_mode, illegal_op
    );

    modport slave (
        input  instr_valid, instruction,
        output instr_ready, inp_buf_we, inp_buf_addr, inp_buf_data,
               wt_buf_we, wt_buf_addr, wt_buf_data,
               acc_result_to_op_buf, acc_to_op_buf_addr,
               op_buffer_instr_for_sending_data, out_buf_addr,
               instr_for_accum_to_reset, state_signal, i_mode, illegal_op
    );
endinterface

// File: rtl/controller_decode.sv
// Combinational field extraction and opcode legality check.
module controller_decode
    import ctrl_pkg::*;
#(
    parameter int INSTR_W = 64,
    parameter int OPC_W   = 5,
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 8
) (
    input  logic [INSTR_W-1:0] instruction,
    output logic [OPC_W-1:0]   opcode,
    output logic [ADDR_W-1:0]  addr,
    output logic [DATA_W-1:0]  data,
    output logic [CNT_W-1:0]   count,
    output logic               legal
);
    localparam int A_LSB = addr_lsb(OPC_W);
    localparam int D_LSB = data_lsb(OPC_W, ADDR_W);
    localparam int C_LSB = cnt_lsb(OPC_W, ADDR_W, DATA_W);

    assign opcode = instruction[OPC_LSB +: OPC_W];
    assign addr   = instruction[A_LSB +: ADDR_W];
    assign data   = instruction[D_LSB +: DATA_W];
    assign count  = instruction[C_LSB +: CNT_W];

    // Only the eight defined opcodes are legal.
    always_comb begin
        legal = (opcode <= OPC_W'(OP_ACC_RST));
    end
endmodule

// File: rtl/controller_seq.sv
// Sequencing instruction controller: single-cycle loads/clears from IDLE,
// multi-beat COMPUTE, DRAIN and SEND driven by a beat counter.
module controller_seq
    import ctrl_pkg::*;
#(
    parameter int INSTR_W    = 64,
    parameter int OPC_W      = 5,
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 32,
    parameter int OUT_ADDR_W = 4,
    parameter int CNT_W      = 8,
    parameter int ARRAY_N    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    controller_seq_if.slave        bus,
    output state_e                 fsm_state
);
    logic [OPC_W-1:0]  opcode;
    logic [ADDR_W-1:0] f_addr;
    logic [DATA_W-1:0] f_data;
    logic [CNT_W-1:0]  f_count;
    logic              f_legal;
    logic              accept;

    controller_decode #(
        .INSTR_W(INSTR_W), .OPC_W(OPC_W), .ADDR_W(ADDR_W),
        .DATA_W(DATA_W), .CNT_W(CNT_W)
    ) u_decode (
        .instruction(bus.instruction), .opcode(opcode), .addr(f_addr),
        .data(f_data), .count(f_count), .legal(f_legal)
    );

    state_e                state_q, state_d;
    logic [CNT_W:0]        beat_q, beat_d, last_q, last_d;
    logic [OUT_ADDR_W-1:0] base_q, base_d;
    logic                  inp_we_q, inp_we_d, wt_we_q, wt_we_d;
    logic [ADDR_W-1:0]     inp_addr_q, inp_addr_d, wt_addr_q, wt_addr_d;
    logic [DATA_W-1:0]     inp_data_q, inp_data_d, wt_data_q, wt_data_d;
    logic                  drain_q, drain_d, send_q, send_d;
    logic [OUT_ADDR_W-1:0] drain_addr_q, drain_addr_d, send_addr_q, send_addr_d;
    logic                  acc_rst_q, acc_rst_d, imode_q, imode_d, illegal_q, illegal_d;
    logic [1:0]            ss_q, ss_d;

    assign bus.instr_ready = rst & (state_q == ST_IDLE);
    assign accept          = bus.instr_valid & bus.instr_ready;

    // Next state, beat counter and next registered outputs; all strobes
    // and their addr/data default to 0 so an idle output reads as 0.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        last_d       = last_q;
        base_d       = base_q;
        inp_we_d     = 1'b0;
        inp_addr_d   = '0;
        inp_data_d   = '0;
        wt_we_d      = 1'b0;
        wt_addr_d    = '0;
        wt_data_d    = '0;
        drain_d      = 1'b0;
        drain_addr_d = '0;
        send_d       = 1'b0;
        send_addr_d  = '0;
        acc_rst_d    = 1'b0;
        imode_d      = 1'b0;
        illegal_d    = 1'b0;
        ss_d         = SS_IDLE;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    beat_d = '0;
                    if (!f_legal) begin
                        illegal_d = 1'b1;
                    end else if (opcode == OPC_W'(OP_LOAD_INP)) begin
                        inp_we_d   = 1'b1;
                        inp_addr_d = f_addr;
                        inp_data_d = f_data;
                        ss_d       = SS_MOVE;
                    end else if (opcode == OPC_W'(OP_LOAD_WT)) begin
                        wt_we_d   = 1'b1;
                        wt_addr_d = f_addr;
                        wt_data_d = f_data;
                        ss_d      = SS_MOVE;
                    end else if (opcode == OPC_W'(OP_ACC_RST)) begin
                        acc_rst_d = 1'b1;
                    end else if (opcode == OPC_W'(OP_COMPUTE_W) || opcode == OPC_W'(OP_COMPUTE_I)) begin
                        state_d = ST_COMPUTE;
                        last_d  = {1'b0, f_count};
                        imode_d = (opcode == OPC_W'(OP_COMPUTE_I));
                        ss_d    = SS_COMP;
                    end else if (opcode == OPC_W'(OP_DRAIN)) begin
                        state_d      = ST_DRAIN;
                        last_d       = (CNT_W+1)'(ARRAY_N - 1);
                        base_d       = f_addr[OUT_ADDR_W-1:0];
                        drain_d      = 1'b1;
                        drain_addr_d = f_addr[OUT_ADDR_W-1:0];
                        ss_d         = SS_MOVE;
                    end else if (opcode == OPC_W'(OP_SEND)) begin
                        state_d     = ST_SEND;
                        last_d      = {1'b0, f_count};
                        base_d      = f_addr[OUT_ADDR_W-1:0];
                        send_d      = 1'b1;
                        send_addr_d = f_addr[OUT_ADDR_W-1:0];
                        ss_d        = SS_MOVE;
                    end
                end
            end
            default: begin
                if (beat_q == last_q) begin
                    state_d = ST_IDLE;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + 1'b1;
                    if (state_q == ST_COMPUTE) begin
                        ss_d    = SS_COMP;
                        imode_d = imode_q;
                    end else if (state_q == ST_DRAIN) begin
                        ss_d         = SS_MOVE;
                        drain_d      = 1'b1;
                        drain_addr_d = base_q + beat_d[OUT_ADDR_W-1:0];
                    end else begin
                        ss_d        = SS_MOVE;
                        send_d      = 1'b1;
                        send_addr_d = base_q + beat_d[OUT_ADDR_W-1:0];
                    end
                end
            end
        endcase
    end

    // State, counter and output registers; synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            beat_q       <= '0;
            last_q       <= '0;
            base_q       <= '0;
            inp_we_q     <= 1'b0;
            inp_addr_q   <= '0;
            inp_data_q   <= '0;
            wt_we_q      <= 1'b0;
            wt_addr_q    <= '0;
            wt_data_q    <= '0;
            drain_q      <= 1'b0;
            drain_addr_q <= '0;
            send_q       <= 1'b0;
            send_addr_q  <= '0;
            acc_rst_q    <= 1'b0;
            imode_q      <= 1'b0;
            illegal_q    <= 1'b0;
            ss_q         <= SS_IDLE;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            last_q       <= last_d;
            base_q       <= base_d;
            inp_we_q     <= inp_we_d;
            inp_addr_q   <= inp_addr_d;
            inp_data_q   <= inp_data_d;
            wt_we_q      <= wt_we_d;
            wt_addr_q    <= wt_addr_d;
            wt_data_q    <= wt_data_d;
            drain_q      <= drain_d;
            drain_addr_q <= drain_addr_d;
            send_q       <= send_d;
            send_addr_q  <= send_addr_d;
            acc_rst_q    <= acc_rst_d;
            imode_q      <= imode_d;
            illegal_q    <= illegal_d;
            ss_q         <= ss_d;
        end
    end

    assign fsm_state                            = state_q;
    assign bus.inp_buf_we                       = inp_we_q;
    assign bus.inp_buf_addr                     = inp_addr_q;
    assign bus.inp_buf_data                     = inp_data_q;
    assign bus.wt_buf_we                        = wt_we_q;
    assign bus.wt_buf_addr                      = wt_addr_q;
    assign bus.wt_buf_data                      = wt_data_q;
    assign bus.acc_result_to_op_buf             = drain_q;
    assign bus.acc_to_op_buf_addr               = drain_addr_q;
    assign bus.op_buffer_instr_for_sending_data = send_q;
    assign bus.out_buf_addr                     = send_addr_q;
    assign bus.instr_for_accum_to_reset         = acc_rst_q;
    assign bus.state_signal                     = ss_q;
    assign bus.i_mode                           = imode_q;
    assign bus.illegal_op                       = illegal_q;
endmodule

// File: tb/tb_controller_seq.sv
// Directed bench for controller_seq: loads, compute, drain wrap, send with
// a held-off second instruction, illegal opcode and mid-operation reset.
module tb_controller_seq;
    import ctrl_pkg::*;

    logic   clk;
    logic   rst;
    state_e fsm_state;
    int     checks;
    int     errors;
    logic [63:0] exp_q[$];

    controller_seq_if #(.INSTR_W(64), .ADDR_W(7), .DATA_W(32), .OUT_ADDR_W(4)) bus ();

    controller_seq dut (
        .clk(clk), .rst(rst), .bus(bus), .fsm_state(fsm_state)
    );

    // Clock and reset.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mk(input logic [4:0] op, input logic [6:0] a,
                                       input logic [31:0] d, input logic [7:0] c);
        logic [63:0] w;
        w = '0;
        w[4:0]   = op;
        w[11:5]  = a;
        w[43:12] = d;
        w[51:44] = c;
        return w;
    endfunction

    task automatic drive(input logic v, input logic [63:0] ins);
        bus.instr_valid = v;
        bus.instruction = ins;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_inp_we"}, 64'(bus.inp_buf_we), 64'd0);
        chk({tag, "_wt_we"}, 64'(bus.wt_buf_we), 64'd0);
        chk({tag, "_drain"}, 64'(bus.acc_result_to_op_buf), 64'd0);
        chk({tag, "_send"}, 64'(bus.op_buffer_instr_for_sending_data), 64'd0);
        chk({tag, "_accrst"}, 64'(bus.instr_for_accum_to_reset), 64'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        drive(1'b0, '0);
        tick();
        tick();

        // Reset state.
        chk("rst_ready", 64'(bus.instr_ready), 64'd0);
        chk("rst_ss", 64'(bus.state_signal), 64'd0);
        chk("rst_fsm", 64'(fsm_state), 64'(ST_IDLE));
        chk_quiet("rst");
        chk("rst_inp_data", 64'(bus.inp_buf_data), 64'd0);
        rst = 1'b1;
        #1;
        chk("rst_rel_ready", 64'(bus.instr_ready), 64'd1);

        // Back-to-back loads.
        drive(1'b1, mk(OP_LOAD_INP, 7'd5, 32'hDEADBEEF, 8'd0));
        tick();
        chk("ld_inp_we", 64'(bus.inp_buf_we), 64'd1);
        chk("ld_inp_addr", 64'(bus.inp_buf_addr), 64'd5);
        chk("ld_inp_data", 64'(bus.inp_buf_data), 64'hDEADBEEF);
        chk("ld_inp_ss", 64'(bus.state_signal), 64'd1);
        chk("ld_ready1", 64'(bus.instr_ready), 64'd1);
        drive(1'b1, mk(OP_LOAD_WT, 7'd9, 32'd1, 8'd0));
        tick();
        chk("ld_wt_we", 64'(bus.wt_buf_we), 64'd1);
        chk("ld_wt_addr", 64'(bus.wt_buf_addr), 64'd9);
        chk("ld_wt_data", 64'(bus.wt_buf_data), 64'd1);
        chk("ld_inp_we_off", 64'(bus.inp_buf_we), 64'd0);
        chk("ld_inp_addr_off", 64'(bus.inp_buf_addr), 64'd0);
        chk("ld_ready2", 64'(bus.instr_ready), 64'd1);
        drive(1'b0, '0);
        tick();
        chk("ld_wt_we_off", 64'(bus.wt_buf_we), 64'd0);
        chk("ld_wt_addr_off", 64'(bus.wt_buf_addr), 64'd0);

        // COMPUTE_I count=3: four beats.
        drive(1'b1, mk(OP_COMPUTE_I, 7'd0, 32'd0, 8'd3));
        tick();
        drive(1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ci_ss_%0d", i), 64'(bus.state_signal), 64'd2);
            chk($sformatf("ci_imode_%0d", i), 64'(bus.i_mode), 64'd1);
            chk($sformatf("ci_ready_%0d", i), 64'(bus.instr_ready), 64'd0);
            tick();
        end
        chk("ci_end_ss", 64'(bus.state_signal), 64'd0);
        chk("ci_end_imode", 64'(bus.i_mode), 64'd0);
        chk("ci_end_ready", 64'(bus.instr_ready), 64'd1);

        // DRAIN addr=14: addresses wrap 14,15,0,1.
        exp_q.push_back(64'd14);
        exp_q.push_back(64'd15);
        exp_q.push_back(64'd0);
        exp_q.push_back(64'd1);
        drive(1'b1, mk(OP_DRAIN, 7'd14, 32'd0, 8'd0));
        tick();
        drive(1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("dr_we_%0d", i), 64'(bus.acc_result_to_op_buf), 64'd1);
            chk($sformatf("dr_addr_%0d", i), 64'(bus.acc_to_op_buf_addr), exp_q.pop_front());
            chk($sformatf("dr_ss_%0d", i), 64'(bus.state_signal), 64'd1);
            tick();
        end
        chk("dr_end_we", 64'(bus.acc_result_to_op_buf), 64'd0);
        chk("dr_end_addr", 64'(bus.acc_to_op_buf_addr), 64'd0);
        chk("dr_end_ready", 64'(bus.instr_ready), 64'd1);

        // SEND addr=2 count=1, second instruction held while busy.
        drive(1'b1, mk(OP_SEND, 7'd2, 32'd0, 8'd1));
        tick();
        drive(1'b1, mk(OP_LOAD_INP, 7'd7, 32'h55, 8'd0));
        chk("sd_b0_we", 64'(bus.op_buffer_instr_for_sending_data), 64'd1);
        chk("sd_b0_addr", 64'(bus.out_buf_addr), 64'd2);
        chk("sd_b0_ready", 64'(bus.instr_ready), 64'd0);
        tick();
        chk("sd_b1_we", 64'(bus.op_buffer_instr_for_sending_data), 64'd1);
        chk("sd_b1_addr", 64'(bus.out_buf_addr), 64'd3);
        chk("sd_b1_inp_we", 64'(bus.inp_buf_we), 64'd0);
        tick();
        chk("sd_end_we", 64'(bus.op_buffer_instr_for_sending_data), 64'd0);
        chk("sd_end_addr", 64'(bus.out_buf_addr), 64'd0);
        chk("sd_end_inp_we", 64'(bus.inp_buf_we), 64'd0);
        chk("sd_end_ready", 64'(bus.instr_ready), 64'd1);
        tick();
        drive(1'b0, '0);
        chk("sd_next_inp_we", 64'(bus.inp_buf_we), 64'd1);
        chk("sd_next_inp_addr", 64'(bus.inp_buf_addr), 64'd7);
        chk("sd_next_inp_data", 64'(bus.inp_buf_data), 64'h55);
        tick();

        // Illegal opcode followed by ACC_RST.
        drive(1'b1, mk(5'b11111, 7'd3, 32'hFFFF, 8'd2));
        tick();
        chk("il_pulse", 64'(bus.illegal_op), 64'd1);
        chk_quiet("il");
        chk("il_ss", 64'(bus.state_signal), 64'd0);
        chk("il_ready", 64'(bus.instr_ready), 64'd1);
        drive(1'b1, mk(OP_ACC_RST, 7'd0, 32'd0, 8'd0));
        tick();
        drive(1'b0, '0);
        chk("il_pulse_off", 64'(bus.illegal_op), 64'd0);
        chk("ar_pulse", 64'(bus.instr_for_accum_to_reset), 64'd1);
        tick();
        chk("ar_pulse_off", 64'(bus.instr_for_accum_to_reset), 64'd0);

        // Reset during beat 2 of COMPUTE_W count=10.
        drive(1'b1, mk(OP_COMPUTE_W, 7'd0, 32'd0, 8'd10));
        tick();
        drive(1'b0, '0);
        chk("cw_b1_ss", 64'(bus.state_signal), 64'd2);
        chk("cw_b1_imode", 64'(bus.i_mode), 64'd0);
        tick();
        chk("cw_b2_ss", 64'(bus.state_signal), 64'd2);
        rst = 1'b0;
        #1;
        chk("cw_rst_ready", 64'(bus.instr_ready), 64'd0);
        tick();
        chk("cw_abort_ss", 64'(bus.state_signal), 64'd0);
        chk("cw_abort_fsm", 64'(fsm_state), 64'(ST_IDLE));
        chk_quiet("cw_abort");
        rst = 1'b1;
        #1;
        chk("cw_rel_ready", 64'(bus.instr_ready), 64'd1);
        tick();
        chk("cw_idle_ss", 64'(bus.state_signal), 64'd0);
        chk("cw_idle_ready", 64'(bus.instr_ready), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
